watch_mode_ctrl: RTL and testbench

//  Top-level sequencer for the watch datapath. Generates the shared 1 Hz tick.

---
 rtl/watch_pkg.sv | 37 +++
 rtl/btn_edge.sv | 22 ++
 rtl/watch_mode_ctrl.sv | 152 +++++++++++++++
 tb/tb_watch_mode_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and constants for the watch datapath: mode codes, sequencer
// states, button indices and the tick counter width helper.
package watch_pkg;

  localparam logic [1:0] MODE_CLOCK = 2'b00;
  localparam logic [1:0] MODE_SW    = 2'b01;
  localparam logic [1:0] MODE_TIMER = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_RING = 1'b1
  } st_e;

  localparam int NUM_BTN     = 5;
  localparam int BTN_MODE    = 0;
  localparam int BTN_START   = 1;
  localparam int BTN_CLR     = 2;
  localparam int BTN_MIN     = 3;
  localparam int BTN_FIVESEC = 4;

  localparam int CLK_HZ_DEF = 100_000_000;

  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int TICK_W = cnt_w(CLK_HZ_DEF);

  function automatic logic [1:0] mode_next(input logic [1:0] m);
    case (m)
      MODE_CLOCK: return MODE_SW;
      MODE_SW:    return MODE_TIMER;
      default:    return MODE_CLOCK;
    endcase
  endfunction

endpackage

// File: rtl/btn_edge.sv
// Per-button rising-edge detector: one registered strobe per low-to-high
// transition of an already synchronised button level.
module btn_edge (
  input  logic clk100MHz,
  input  logic rst,
  input  logic btn,
  output logic strobe
);

  logic prev;

  always_ff @(posedge clk100MHz) begin
    if (!rst) begin
      prev   <= 1'b0;
      strobe <= 1'b0;
    end else begin
      prev   <= btn;
      strobe <= btn & ~prev;
    end
  end

endmodule

// File: rtl/watch_mode_ctrl.sv
// Watch sequencer: 1 Hz tick, button strobe arbitration, mode select and the
// timer-expiry ring. Optional idle auto-return to clock mode: WATCH_AUTO_RETURN_EN.
module watch_mode_ctrl
  import watch_pkg::*;
#(
  parameter int CLK_HZ   = CLK_HZ_DEF,
  parameter int RING_SEC = 10,
  parameter int IDLE_SEC = 30
) (
  input  logic       clk100MHz,
  input  logic       rst,
  input  logic       btn_mode,
  input  logic       btn_start,
  input  logic       btn_clr,
  input  logic       btn_min,
  input  logic       btn_fivesec,
  input  logic       timer_zero,
  output logic [1:0] sel,
  output logic       tick_1hz,
  output logic       start_pulse,
  output logic       clr_pulse,
  output logic       min_pulse,
  output logic       fivesec_pulse,
  output logic       ringing,
  output logic       beep
);

  localparam int CW = (CLK_HZ == CLK_HZ_DEF) ? TICK_W : cnt_w(CLK_HZ);
  localparam int SW = cnt_w(RING_SEC + 1);

  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_HZ - 1);
  localparam logic [CW-1:0] CNT_Q1  = CW'(CLK_HZ / 4);
  localparam logic [CW-1:0] CNT_H   = CW'(CLK_HZ / 2);
  localparam logic [CW-1:0] CNT_Q3  = CW'((3 * CLK_HZ) / 4);
  localparam logic [SW-1:0] RING_LAST = SW'(RING_SEC - 1);

  logic [CW-1:0]      cnt;
  logic [NUM_BTN-1:0] btn_v, edg;
  logic               any_edge;
  logic               tz_prev;
  logic               expire;

  st_e         st, st_nxt;
  logic [1:0]  sel_q, sel_nxt;
  logic        armed, armed_nxt;
  logic [SW-1:0] ring_cnt, ring_nxt;

  // 1 Hz timebase shared by all counter blocks and the beep phase
  always_ff @(posedge clk100MHz) begin
    if (!rst)                cnt <= '0;
    else if (cnt == CNT_MAX) cnt <= '0;
    else                     cnt <= cnt + 1'b1;
  end

  assign tick_1hz = (cnt == CNT_MAX);

  assign btn_v = {btn_fivesec, btn_min, btn_clr, btn_start, btn_mode};

  btn_edge u_edge [NUM_BTN-1:0] (
    .clk100MHz (clk100MHz),
    .rst       (rst),
    .btn       (btn_v),
    .strobe    (edg)
  );

  assign any_edge = |edg;

  always_ff @(posedge clk100MHz) begin
    if (!rst) tz_prev <= 1'b0;
    else      tz_prev <= timer_zero;
  end

  // Expiry is judged ahead of the buttons so a same-cycle press cannot mask it
  assign expire = (st == ST_RUN) & armed & timer_zero & ~tz_prev;

`ifdef WATCH_AUTO_RETURN_EN
  localparam int IW = cnt_w(IDLE_SEC + 1);
  localparam logic [IW-1:0] IDLE_TOP = IW'(IDLE_SEC);

  logic [IW-1:0] idle_cnt;
  logic          idle_hit;

  always_ff @(posedge clk100MHz) begin
    if (!rst)                                idle_cnt <= '0;
    else if (any_edge)                       idle_cnt <= '0;
    else if (tick_1hz && idle_cnt != IDLE_TOP) idle_cnt <= idle_cnt + 1'b1;
  end

  assign idle_hit = (idle_cnt == IDLE_TOP);
`endif

  always_comb begin
    st_nxt        = st;
    sel_nxt       = sel_q;
    armed_nxt     = armed;
    ring_nxt      = ring_cnt;
    start_pulse   = 1'b0;
    clr_pulse     = 1'b0;
    min_pulse     = 1'b0;
    fivesec_pulse = 1'b0;
    case (st)
      ST_RUN: begin
        if (expire) begin
          st_nxt    = ST_RING;
          armed_nxt = 1'b0;
          ring_nxt  = '0;
        end else if (edg[BTN_MODE]) begin
          sel_nxt = mode_next(sel_q);
        end else if (edg[BTN_START]) begin
          start_pulse = 1'b1;
          if (sel_q == MODE_TIMER && !timer_zero) armed_nxt = 1'b1;
        end else if (edg[BTN_CLR]) begin
          clr_pulse = 1'b1;
          armed_nxt = 1'b0;
        end else if (edg[BTN_MIN]) begin
          min_pulse = 1'b1;
        end else if (edg[BTN_FIVESEC]) begin
          fivesec_pulse = 1'b1;
        end
`ifdef WATCH_AUTO_RETURN_EN
        if (!expire && !any_edge && idle_hit && sel_q != MODE_CLOCK && !armed)
          sel_nxt = MODE_CLOCK;
`endif
      end
      ST_RING: begin
        // any button acknowledges the ring and is swallowed
        if (any_edge || (tick_1hz && ring_cnt == RING_LAST)) st_nxt = ST_RUN;
        else if (tick_1hz)                                    ring_nxt = ring_cnt + 1'b1;
      end
      default: st_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk100MHz) begin
    if (!rst) begin
      st       <= ST_RUN;
      sel_q    <= MODE_CLOCK;
      armed    <= 1'b0;
      ring_cnt <= '0;
    end else begin
      st       <= st_nxt;
      sel_q    <= sel_nxt;
      armed    <= armed_nxt;
      ring_cnt <= ring_nxt;
    end
  end

  assign sel     = sel_q;
  assign ringing = (st == ST_RING);
  assign beep    = ringing & ((cnt < CNT_Q1) | ((cnt >= CNT_H) & (cnt < CNT_Q3)));

endmodule

// File: tb/tb_watch_mode_ctrl.sv
// Self-checking bench for watch_mode_ctrl: directed scenarios plus random
// button/timer_zero traffic against a cycle-level behavioural model.
module tb_watch_mode_ctrl;

  localparam int HZ   = 8;
  localparam int RSEC = 3;
  localparam int ISEC = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       btn_mode = 1'b0, btn_start = 1'b0, btn_clr = 1'b0;
  logic       btn_min = 1'b0, btn_fivesec = 1'b0, timer_zero = 1'b0;
  logic [1:0] sel;
  logic       tick_1hz, start_pulse, clr_pulse, min_pulse, fivesec_pulse;
  logic       ringing, beep;

  watch_mode_ctrl #(.CLK_HZ(HZ), .RING_SEC(RSEC), .IDLE_SEC(ISEC)) dut (
    .clk100MHz     (clk),
    .rst           (rst),
    .btn_mode      (btn_mode),
    .btn_start     (btn_start),
    .btn_clr       (btn_clr),
    .btn_min       (btn_min),
    .btn_fivesec   (btn_fivesec),
    .timer_zero    (timer_zero),
    .sel           (sel),
    .tick_1hz      (tick_1hz),
    .start_pulse   (start_pulse),
    .clr_pulse     (clr_pulse),
    .min_pulse     (min_pulse),
    .fivesec_pulse (fivesec_pulse),
    .ringing       (ringing),
    .beep          (beep)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int saw_ring = 0;

  // model: phase within the second, mode 0/1/2, timer armed, ring progress,
  // idle seconds, and the button/timer_zero levels of the two previous cycles
  int         m_phase, m_mode, m_rticks, m_idle;
  bit         m_armed, m_ring, m_tz1;
  logic [4:0] m_b1, m_b2;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_mode = 0; m_rticks = 0; m_idle = 0;
    m_armed = 0; m_ring = 0; m_tz1 = 0; m_b1 = '0; m_b2 = '0;
  endtask

  // bits: 0 mode, 1 start, 2 clr, 3 min, 4 fivesec
  task automatic eval(input logic [4:0] b, input logic tz);
    logic [4:0] e;
    bit tk, expiry, p_s, p_c, p_m, p_f, bp, force0;
    {btn_fivesec, btn_min, btn_clr, btn_start, btn_mode} = b;
    timer_zero = tz;
    #1;
    e  = m_b1 & ~m_b2;
    tk = (m_phase == HZ - 1);
    expiry = !m_ring && m_armed && tz && !m_tz1;
    p_s = 0; p_c = 0; p_m = 0; p_f = 0;
    if (!m_ring && !expiry && !e[0]) begin
      if (e[1])      p_s = 1;
      else if (e[2]) p_c = 1;
      else if (e[3]) p_m = 1;
      else if (e[4]) p_f = 1;
    end
    bp = m_ring && ((m_phase % (HZ / 2)) < (HZ / 4));
    chk("tick", tick_1hz, tk);
    chk("sel", sel, m_mode);
    chk("start_pulse", start_pulse, p_s);
    chk("clr_pulse", clr_pulse, p_c);
    chk("min_pulse", min_pulse, p_m);
    chk("fivesec_pulse", fivesec_pulse, p_f);
    chk("ringing", ringing, m_ring);
    chk("beep", beep, bp);
    if (ringing) saw_ring++;
    force0 = 0;
`ifdef WATCH_AUTO_RETURN_EN
    force0 = !m_ring && !expiry && e == 0 && m_idle == ISEC && m_mode != 0 && !m_armed;
    if (e != 0) m_idle = 0;
    else if (tk && m_idle < ISEC) m_idle++;
`endif
    if (m_ring) begin
      if (tk) m_rticks++;
      if (e != 0 || m_rticks == RSEC) m_ring = 0;
    end else if (expiry) begin
      m_ring = 1; m_rticks = 0; m_armed = 0;
    end else if (e[0]) begin
      m_mode = (m_mode + 1) % 3;
    end else if (e[1]) begin
      if (m_mode == 2 && !tz) m_armed = 1;
    end else if (e[2]) begin
      m_armed = 0;
    end
    if (force0) m_mode = 0;
    m_phase = (m_phase + 1) % HZ;
    m_tz1 = tz;
    m_b2 = m_b1;
    m_b1 = b;
  endtask

  task automatic step(input logic [4:0] b, input logic tz);
    @(posedge clk); #1;
    eval(b, tz);
  endtask

  task automatic do_reset(input logic tz);
    @(posedge clk); #1;
    rst = 1'b0;
    {btn_fivesec, btn_min, btn_clr, btn_start, btn_mode} = '0;
    timer_zero = tz;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    chk("rst_sel", sel, 0);
    chk("rst_ringing", ringing, 0);
    chk("rst_beep", beep, 0);
    chk("rst_pulses", {start_pulse, clr_pulse, min_pulse, fivesec_pulse}, 0);
    model_reset();
    eval('0, tz);
  endtask

  task automatic press(input int idx, input int hold, input logic tz);
    logic [4:0] b;
    b = '0;
    b[idx] = 1'b1;
    repeat (hold) step(b, tz);
    repeat (3) step('0, tz);
  endtask

  initial begin
    logic [4:0] rb;
    logic       rtz;
    int         k;
    model_reset();
    do_reset(1'b0);

    // tick cadence and idle outputs after reset
    repeat (17) step('0, 1'b0);

    // mode cycling, long hold gives one step
    press(0, 2, 1'b0);
    press(0, 2, 1'b0);
    chk("sel_timer", sel, 2);
    press(0, 2, 1'b0);
    chk("sel_wrap", sel, 0);
    press(0, 20, 1'b0);
    chk("sel_hold", sel, 1);
    press(0, 1, 1'b0);
    press(0, 1, 1'b0);

    // start beats min; mode beats everything
    step(5'b01010, 1'b0);
    step('0, 1'b0);
    chk("arb_start", start_pulse, 1);
    chk("arb_min", min_pulse, 0);
    step('0, 1'b0);
    step(5'b01011, 1'b0);
    step('0, 1'b0);
    chk("arb_mode_start", start_pulse, 0);
    repeat (2) step('0, 1'b0);
    chk("arb_mode_sel", sel, 1);
    press(0, 1, 1'b0);

    // arm in timer mode, expire, ring runs its full length
    press(1, 1, 1'b0);
    step('0, 1'b1);
    step('0, 1'b1);
    chk("ring_on", ringing, 1);
    repeat (30) step('0, 1'b1);
    chk("ring_done", ringing, 0);
    chk("ring_sel", sel, 2);

    // acknowledge by clr, then mid-ring reset
    press(1, 1, 1'b0);
    repeat (2) step('0, 1'b1);
    press(2, 1, 1'b1);
    chk("ack_ringing", ringing, 0);
    step('0, 1'b0);
    press(1, 1, 1'b0);
    repeat (4) step('0, 1'b1);
    chk("ring_again", ringing, 1);
    do_reset(1'b1);
    chk("midrst_sel", sel, 0);
    chk("midrst_ring", ringing, 0);

`ifdef WATCH_AUTO_RETURN_EN
    step('0, 1'b0);
    press(0, 1, 1'b0);
    repeat (45) step('0, 1'b0);
    chk("auto_ret", sel, 0);
    press(0, 1, 1'b0);
    press(0, 1, 1'b0);
    press(1, 1, 1'b0);
    repeat (45) step('0, 1'b0);
    chk("auto_armed", sel, 2);
    do_reset(1'b0);
`endif

    rb = '0;
    rtz = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        k = $urandom_range(0, 4);
        if (k != 0 || $urandom_range(0, 2) == 0) rb[k] = ~rb[k];
      end
      if ($urandom_range(0, 24) == 0) rtz = ~rtz;
      if (i == 1500) do_reset(rtz);
      else           step(rb, rtz);
    end
    chk("saw_ring", saw_ring > 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
